// File: rtl/posit_encoder.sv
// rtl/posit_encoder.sv - 3-stage posit field packer with RNE rounding and saturation
//
// Purpose:
//   Takes a normalised result (sign, scale, fraction below the hidden 1, sticky,
//   zero/NaR flags) and produces the N-bit posit word plus an inexact flag.
//   S1 splits the scale into regime/exponent and detects saturation. S2 lays the
//   regime, exponent and fraction into a wide buffer and extracts the magnitude,
//   guard and sticky bits. S3 rounds to nearest even, clamps and negates.
//   All stages advance together whenever the output register is empty or drained.
//
// Ports:
//   ap_clk      in   clock, rising edge
//   ap_rst_n    in   asynchronous active-low reset
//   in_valid    in   input fields valid
//   in_ready    out  block accepts input this cycle
//   in_sign     in   1 = negative
//   in_scale    in   signed scale of 1.frac * 2^scale
//   in_frac     in   fraction bits below the hidden 1, MSB-aligned
//   in_sticky   in   OR of discarded bits below in_frac[0]
//   in_zero     in   result is exactly zero
//   in_nar      in   result is NaR (overrides zero)
//   out_valid   out  out_posit valid
//   out_ready   in   downstream accepts out_posit
//   out_posit   out  encoded posit
//   out_inexact out  rounding or saturation changed the value
module posit_encoder #(
  parameter int N  = 32,
  parameter int ES = 2,
  parameter int FW = 28,
  parameter int SW = 8
) (
  input  logic          ap_clk,
  input  logic          ap_rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic [SW-1:0] in_scale,
  input  logic [FW-1:0] in_frac,
  input  logic          in_sticky,
  input  logic          in_zero,
  input  logic          in_nar,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_posit,
  output logic          out_inexact
);

  // Buffer holds {terminator, exponent, fraction} plus enough zero padding that
  // no shift of up to N-1 regime bits can push information off the bottom.
  localparam int BW = 1 + ES + FW + N + 1;
  localparam int KW = SW - ES + 1;
  localparam logic signed [SW-1:0] MAX_SCALE = SW'((N - 2) * (2 ** ES));

  logic w_adv;
  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = w_adv;

  // ---------------- S1: regime length and saturation ----------------
  logic signed [SW-1:0] w_scale;
  logic signed [KW-1:0] w_k;
  logic        [KW-1:0] w_shamt;
  logic                 w_sat_hi;
  logic                 w_sat_lo;

  assign w_scale  = $signed(in_scale);
  // Dropping the low ES bits of a two's complement scale is a floor divide.
  assign w_k      = $signed({in_scale[SW-1], in_scale[SW-1:ES]});
  // Number of leading regime fill bits before the terminating bit.
  assign w_shamt  = w_k[KW-1] ? KW'(-w_k) : KW'(w_k + KW'(1));
  assign w_sat_hi = w_scale > MAX_SCALE;
  assign w_sat_lo = w_scale < -MAX_SCALE;

  logic          r_s1_valid, r_s1_sign, r_s1_zero, r_s1_nar;
  logic          r_s1_sat_hi, r_s1_sat_lo, r_s1_fill, r_s1_sticky;
  logic [KW-1:0] r_s1_shamt;
  logic [ES-1:0] r_s1_e;
  logic [FW-1:0] r_s1_frac;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_zero   <= 1'b0;
      r_s1_nar    <= 1'b0;
      r_s1_sat_hi <= 1'b0;
      r_s1_sat_lo <= 1'b0;
      r_s1_fill   <= 1'b0;
      r_s1_sticky <= 1'b0;
      r_s1_shamt  <= '0;
      r_s1_e      <= '0;
      r_s1_frac   <= '0;
    end else if (w_adv) begin
      r_s1_valid  <= in_valid;
      r_s1_sign   <= in_sign;
      r_s1_zero   <= in_zero;
      r_s1_nar    <= in_nar;
      r_s1_sat_hi <= w_sat_hi;
      r_s1_sat_lo <= w_sat_lo;
      r_s1_fill   <= ~w_k[KW-1];
      r_s1_sticky <= in_sticky;
      r_s1_shamt  <= w_shamt;
      r_s1_e      <= in_scale[ES-1:0];
      r_s1_frac   <= in_frac;
    end
  end

  // ---------------- S2: lay out bits, extract guard/sticky ----------------
  // k>=0: fill with ones, terminator 0. k<0: fill with zeros, terminator 1.
  logic [BW-1:0] w_tail;
  logic [BW-1:0] w_fill_mask;
  logic [BW-1:0] w_shifted;

  assign w_tail      = {~r_s1_fill, r_s1_e, r_s1_frac, {(N + 1){1'b0}}};
  assign w_fill_mask = ~({BW{1'b1}} >> r_s1_shamt);
  assign w_shifted   = (w_tail >> r_s1_shamt) | (r_s1_fill ? w_fill_mask : '0);

  logic         r_s2_valid, r_s2_sign, r_s2_zero, r_s2_nar, r_s2_sat;
  logic         r_s2_guard, r_s2_sticky;
  logic [N-2:0] r_s2_mag;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_s2_valid  <= 1'b0;
      r_s2_sign   <= 1'b0;
      r_s2_zero   <= 1'b0;
      r_s2_nar    <= 1'b0;
      r_s2_sat    <= 1'b0;
      r_s2_guard  <= 1'b0;
      r_s2_sticky <= 1'b0;
      r_s2_mag    <= '0;
    end else if (w_adv) begin
      r_s2_valid <= r_s1_valid;
      r_s2_sign  <= r_s1_sign;
      r_s2_zero  <= r_s1_zero;
      r_s2_nar   <= r_s1_nar;
      r_s2_sat   <= r_s1_sat_hi | r_s1_sat_lo;
      if (r_s1_sat_hi) begin
        r_s2_mag    <= {(N - 1){1'b1}};
        r_s2_guard  <= 1'b0;
        r_s2_sticky <= 1'b0;
      end else if (r_s1_sat_lo) begin
        r_s2_mag    <= {{(N - 2){1'b0}}, 1'b1};
        r_s2_guard  <= 1'b0;
        r_s2_sticky <= 1'b0;
      end else begin
        r_s2_mag    <= w_shifted[BW-1 -: N-1];
        r_s2_guard  <= w_shifted[BW-N];
        r_s2_sticky <= (|w_shifted[BW-N-1:0]) | r_s1_sticky;
      end
    end
  end

  // ---------------- S3: RNE, clamp, sign, specials ----------------
  logic         w_inc;
  logic [N-2:0] w_mag_r;
  logic [N-2:0] w_mag_f;
  logic [N-1:0] w_word;
  logic [N-1:0] w_posit;
  logic         w_inexact;

  // Rounding up from maxpos would wrap into NaR, so it is suppressed.
  assign w_inc   = r_s2_guard & (r_s2_sticky | r_s2_mag[0]) & ~(&r_s2_mag);
  assign w_mag_r = r_s2_mag + {{(N - 2){1'b0}}, w_inc};
  assign w_mag_f = (w_mag_r == '0) ? {{(N - 2){1'b0}}, 1'b1} : w_mag_r;
  assign w_word  = {1'b0, w_mag_f};

  always_comb begin
    w_posit   = r_s2_sign ? (~w_word + {{(N - 1){1'b0}}, 1'b1}) : w_word;
    w_inexact = r_s2_guard | r_s2_sticky | r_s2_sat;
    if (r_s2_nar) begin
      w_posit   = {1'b1, {(N - 1){1'b0}}};
      w_inexact = 1'b0;
    end else if (r_s2_zero) begin
      w_posit   = '0;
      w_inexact = 1'b0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid   <= 1'b0;
      out_posit   <= '0;
      out_inexact <= 1'b0;
    end else if (w_adv) begin
      out_valid   <= r_s2_valid;
      out_posit   <= w_posit;
      out_inexact <= w_inexact;
    end
  end

endmodule

// File: tb/tb_posit_encoder.sv
// tb/tb_posit_encoder.sv - randomized scoreboard bench for posit_encoder
module tb_posit_encoder;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_scale;
  logic [27:0] in_frac;
  logic        in_sticky;
  logic        in_zero;
  logic        in_nar;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_posit;
  logic        out_inexact;

  int n_checks = 0;
  int n_errors = 0;
  bit rand_ready = 1'b0;
  logic [32:0] exp_q[$];

  posit_encoder dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sign     (in_sign),
    .in_scale    (in_scale),
    .in_frac     (in_frac),
    .in_sticky   (in_sticky),
    .in_zero     (in_zero),
    .in_nar      (in_nar),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_posit   (out_posit),
    .out_inexact (out_inexact)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: write the posit bit string out as a list of bits, then read
  // the first 31 as magnitude and the rest as guard/sticky.
  function automatic logic [32:0] model(bit sg, int sc, logic [27:0] fr, bit st, bit z, bit n);
    bit          q[$];
    logic [30:0] mag;
    logic [31:0] word;
    bit          g;
    bit          s;
    bit          inx;
    int          k;
    int          e;
    if (n) return {1'b0, 32'h8000_0000};
    if (z) return 33'h0;
    g = 0;
    s = 0;
    if (sc > 120) begin
      mag = 31'h7FFF_FFFF;
      inx = 1;
    end else if (sc < -120) begin
      mag = 31'h1;
      inx = 1;
    end else begin
      k = sc / 4;
      if (sc < 0 && (sc % 4) != 0) k = k - 1;
      e = sc - 4 * k;
      if (k >= 0) begin
        repeat (k + 1) q.push_back(1'b1);
        q.push_back(1'b0);
      end else begin
        repeat (-k) q.push_back(1'b0);
        q.push_back(1'b1);
      end
      q.push_back(e[1]);
      q.push_back(e[0]);
      for (int i = 27; i >= 0; i--) q.push_back(fr[i]);
      mag = '0;
      for (int i = 0; i < 31; i++) mag = {mag[29:0], q[i]};
      g = q[31];
      s = st;
      for (int i = 32; i < q.size(); i++) s = s | q[i];
      inx = g | s;
      if (g && (s || mag[0]) && mag != 31'h7FFF_FFFF) mag = mag + 31'h1;
      if (mag == 31'h0) mag = 31'h1;
    end
    word = {1'b0, mag};
    if (sg) word = -word;
    return {inx, word};
  endfunction

  task automatic send(bit sg, int sc, logic [27:0] fr, bit st, bit z, bit n, logic [32:0] exp);
    int t;
    in_valid  = 1'b1;
    in_sign   = sg;
    in_scale  = 8'(sc);
    in_frac   = fr;
    in_sticky = st;
    in_zero   = z;
    in_nar    = n;
    t = 0;
    forever begin
      @(negedge ap_clk);
      if (in_ready) begin
        @(posedge ap_clk);
        exp_q.push_back(exp);
        break;
      end
      t++;
      if (t > 1000) begin
        check("send_timeout", 64'(in_ready), 64'd1);
        break;
      end
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_m(bit sg, int sc, logic [27:0] fr, bit st, bit z, bit n);
    send(sg, sc, fr, st, z, n, model(sg, sc, fr, st, z, n));
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge ap_clk);
      t++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    @(posedge ap_clk);
    #1;
  endtask

  // Random backpressure
  initial begin
    forever begin
      @(posedge ap_clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Output monitor: scoreboard compare and stall-stability
  initial begin
    logic [32:0] e;
    logic [32:0] prev;
    bit          prev_stall;
    prev_stall = 0;
    prev = '0;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin
        prev_stall = 0;
      end else begin
        if (prev_stall)
          check("stable", {31'd0, out_valid, out_inexact, out_posit}, {31'd0, 1'b1, prev});
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("spurious", 64'(out_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("out", {31'd0, out_inexact, out_posit}, {31'd0, e});
          end
        end
        prev_stall = out_valid && !out_ready;
        prev = {out_inexact, out_posit};
      end
    end
  end

  initial begin
    int sc;
    ap_rst_n  = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_scale  = '0;
    in_frac   = '0;
    in_sticky = 1'b0;
    in_zero   = 1'b0;
    in_nar    = 1'b0;
    out_ready = 1'b1;
    #3;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_posit", 64'(out_posit), 64'd0);
    check("rst_inexact", 64'(out_inexact), 64'd0);
    @(posedge ap_clk);
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;

    // Latency: third edge counting the accepting one
    send(0, 0, 28'h0, 0, 0, 0, {1'b0, 32'h4000_0000});
    @(negedge ap_clk);
    check("lat_e1", 64'(out_valid), 64'd0);
    @(negedge ap_clk);
    check("lat_e2", 64'(out_valid), 64'd0);
    @(negedge ap_clk);
    check("lat_e3", 64'(out_valid), 64'd1);
    @(posedge ap_clk);
    #1;

    rand_ready = 1'b1;
    send(1,    0, 28'h0000000, 0, 0, 0, {1'b0, 32'hC000_0000});
    send(0,    1, 28'h0000000, 0, 0, 0, {1'b0, 32'h4800_0000});
    send(0,   -1, 28'h0000000, 0, 0, 0, {1'b0, 32'h3800_0000});
    send(0,    4, 28'h0000000, 0, 0, 0, {1'b0, 32'h6000_0000});
    send(0,    0, 28'h0000001, 0, 0, 0, {1'b1, 32'h4000_0000});
    send(0,    0, 28'h0000003, 0, 0, 0, {1'b1, 32'h4000_0002});
    send(0,    0, 28'h0000001, 1, 0, 0, {1'b1, 32'h4000_0001});
    send(0,  127, 28'h0000000, 0, 0, 0, {1'b1, 32'h7FFF_FFFF});
    send(0, -128, 28'h0000000, 0, 0, 0, {1'b1, 32'h0000_0001});
    send(1, -128, 28'h0000000, 0, 0, 0, {1'b1, 32'hFFFF_FFFF});
    send(1,    5, 28'h1234567, 1, 0, 1, {1'b0, 32'h8000_0000});
    send(1,    5, 28'h1234567, 1, 1, 0, {1'b0, 32'h0000_0000});
    send(0,  120, 28'h0000000, 0, 0, 0, {1'b0, 32'h7FFF_FFFF});
    send(0, -120, 28'h0000000, 0, 0, 0, {1'b0, 32'h0000_0001});
    send_m(0,  121, 28'h0000000, 0, 0, 0);
    send_m(0, -121, 28'h0000000, 0, 0, 0);
    send_m(0,  119, 28'hFFFFFFF, 1, 0, 0);
    send_m(1, -119, 28'hABCDEF0, 0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0:       sc = int'($urandom_range(0, 255)) - 128;
        1:       sc = int'($urandom_range(0, 16)) - 8;
        2:       sc = int'($urandom_range(114, 126)) * ($urandom_range(0, 1) != 0 ? 1 : -1);
        default: sc = int'($urandom_range(0, 80)) - 40;
      endcase
      send_m(1'($urandom_range(0, 1)), sc, 28'($urandom()), 1'($urandom_range(0, 1)),
             $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge ap_clk);
      #1;
    end
    wait_drain();

    // Fill the pipe under full stall, then reset it
    rand_ready = 1'b0;
    out_ready  = 1'b0;
    send_m(0, 3, 28'h1111111, 0, 0, 0);
    send_m(1, 9, 28'h2222222, 0, 0, 0);
    send_m(0, -7, 28'h3333333, 1, 0, 0);
    check("full_valid", 64'(out_valid), 64'd1);
    check("full_ready", 64'(in_ready), 64'd0);
    ap_rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_posit", 64'(out_posit), 64'd0);
    exp_q.delete();
    @(posedge ap_clk);
    @(posedge ap_clk);
    #1;
    ap_rst_n  = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(posedge ap_clk);
    #1;
    check("post_rst_idle", 64'(out_valid), 64'd0);
    send(0, 4, 28'h0000000, 0, 0, 0, {1'b0, 32'h6000_0000});
    wait_drain();
    repeat (4) @(posedge ap_clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
